intra_frame_store: RTL
======================

# intra_frame_store

Parametrised successor to the single-cycle macroblock saver in the intra-prediction path. It accepts reconstructed macroblocks over a valid/ready handshake and writes them row by row into a single-port frame RAM. It also serves neighbour-pixel fetches (top row, left column) back to the intra predictor, with availability flags and default fill at frame edges. It sits between the reconstruction adder and the predictor and is the only owner of reconstructed-frame storage.

## Interface
- FRAME_W, 1280: frame width in pixels; multiple of MB_W.
- FRAME_H, 720: frame height in pixels; multiple of MB_H.
- MB_W, 8: macroblock width in pixels.
- MB_H, 8: macroblock height in pixels.
- PIX_BITS, 8: bits per pixel.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  macroblock offered.
- in_ready  out  1  block can accept a macroblock.
- in_mbnumber  in  32  {row[31:16], col[15:0]}: pixel coordinates of the top-left pixel.
- in_pixels  in  MB_W*MB_H*PIX_BITS  raster order; pixel (i,j) is at bits [(i*MB_W+j)*PIX_BITS +: PIX_BITS].
- wr_done  out  1  one-cycle pulse when the last row of an accepted macroblock is written.
- wr_err  out  1  one-cycle pulse when an accepted macroblock is rejected.
- nb_req  in  1  neighbour fetch requested.
- nb_ready  out  1  fetch can be accepted.
- nb_mbnumber  in  32  target macroblock coordinates, same format as in_mbnumber.
- nb_valid  out  1  one-cycle pulse; neighbour outputs are valid.
- nb_top  out  MB_W*PIX_BITS  the row above the target macroblock.
- nb_left  out  MB_H*PIX_BITS  the column to the left of the target macroblock.
- nb_top_avail, nb_left_avail  out  1 each  neighbour exists inside the frame.

## Operation
- The RAM holds FRAME_H × (FRAME_W/MB_W) words of MB_W*PIX_BITS bits.
  - Word address = row*(FRAME_W/MB_W) + col/MB_W.
  - The RAM has one port and a 1-cycle synchronous read.
- FSM states: IDLE, WRITE, RD_TOP, RD_LEFT, RD_DONE.
- IDLE behaviour:
  - in_ready = nb_ready = 1, except that nb_ready = 0 whenever in_valid = 1.
  - Writes win over reads on a simultaneous request.
- Write accept (in_valid & in_ready):
  - Capture pixels and coordinates into an MB buffer.
  - Validate: col % MB_W == 0, row % MB_H == 0, col+MB_W ≤ FRAME_W, row+MB_H ≤ FRAME_H.
  - If invalid: pulse wr_err next cycle, stay IDLE, perform no RAM write.
  - If valid: go to WRITE.
- WRITE:
  - Write buffer row k to RAM row row+k in cycle k (k = 0..MB_H-1).
  - After row MB_H-1, pulse wr_done and return to IDLE.
- Fetch accept (nb_req & nb_ready):
  - Capture coordinates and go to RD_TOP.
  - RD_TOP (1 cycle): read word (row-1, col/MB_W).
  - RD_LEFT (MB_H cycles): read word (row+k, col/MB_W-1) and keep pixel MB_W-1 of each as left[k].
  - RD_DONE: capture the final read data, pulse nb_valid, return to IDLE.
- Availability:
  - nb_top_avail = (row != 0); nb_left_avail = (col != 0).
  - An unavailable neighbour is driven as all pixels = 2^(PIX_BITS-1). The read for it is still issued, but its address is clamped to 0 and the data is discarded.
- Fetch coordinates are not range-checked beyond the edge rules. Out-of-frame fetch results are undefined, and the RAM must not be corrupted by them.
- Address arithmetic uses 32-bit intermediates; there is no wrap-around.

## Timing
- Reset values:
  - FSM = IDLE; in_ready = nb_ready = 1.
  - wr_done = wr_err = nb_valid = 0; nb_* data = 0; avail flags = 0.
  - RAM contents are not cleared.
- Write: accept at edge 0, rows written at edges 1..MB_H, wr_done high in cycle MB_H+1. in_ready is low from the accept until the return to IDLE.
- Reject: wr_err high in the cycle after accept; in_ready stays 1.
- Fetch: accept at edge 0, nb_valid high in cycle MB_H+3. nb_* data holds until the next nb_valid.
- Back-to-back: a new accept is allowed in the cycle wr_done or nb_valid is high.
- Reset mid-operation aborts to IDLE. A partially written macroblock stays partially written, and no done pulse is generated.

## Structure
- intra_pkg holds:
  - the state enum;
  - the mbnumber field helpers (row/col extract);
  - the MID_PIXEL = 2^(PIX_BITS-1) constant function.
- Sub-module frame_store_ram: parametrised single-port synchronous RAM (depth, width), write-first.

## Test plan
- Write MB at (0,0) with pixel = i*8+j → wr_done at cycle 9; a fetch of (8,0) returns nb_top = 56..63, nb_left_avail = 0, nb_left all 128.
- Write (0,8) and (0,0), then fetch (0,8) → nb_top_avail = 0, nb_top all 128, nb_left = pixel 7 of rows 0..7 of MB (0,0) = 7,15,…,63.
- Misaligned write (row 3, col 0) and out-of-frame write (row 720) → wr_err pulse, RAM unchanged (verified by a subsequent fetch).
- Simultaneous in_valid and nb_req in IDLE → write accepted, nb_ready = 0; fetch accepted the cycle wr_done is high, nb_valid 11 cycles later.
- Assert reset during WRITE row 4 → outputs take reset values immediately; rows 0..3 hold new data, rows 4..7 hold old data; no wr_done.
- Last MB at (712,1272) → written without error; fetch of (712,1272) returns correct top and left data with both avail flags = 1.

Source files
------------

// File: rtl/intra_pkg.sv
// Shared state type and helpers for the intra-prediction reconstructed-frame store.
package intra_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_TOP,
        RD_LEFT,
        RD_DONE
    } state_t;

    // mbnumber packs {row, col}; both helpers return 32-bit values so address math stays wide.
    function automatic logic [31:0] mb_row(input logic [31:0] mbnumber);
        return mbnumber >> 16;
    endfunction

    function automatic logic [31:0] mb_col(input logic [31:0] mbnumber);
        return mbnumber & 32'h0000_FFFF;
    endfunction

    function automatic int unsigned mid_pixel(input int unsigned pix_bits);
        return 32'd1 << (pix_bits - 1);
    endfunction

endpackage

// File: rtl/frame_store_ram.sv
// Single-port synchronous RAM, write-first, one-cycle read latency.
module frame_store_ram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [31:0]      i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_in_range;

    // Addresses past the end never touch the array, so stray fetches cannot corrupt it.
    assign w_in_range = (i_addr < 32'(DEPTH));

    // NOTE: the array has no reset; clearing it would force a flop-based implementation.
    always_ff @(posedge clk) begin
        if (i_we && w_in_range) begin
            r_mem[i_addr[AW-1:0]] <= i_wdata;
            o_rdata               <= i_wdata;
        end else if (w_in_range) begin
            o_rdata <= r_mem[i_addr[AW-1:0]];
        end else begin
            o_rdata <= '0;
        end
    end

endmodule

// File: rtl/intra_frame_store.sv
// Reconstructed-frame store: writes macroblocks row by row into a single-port RAM and
// serves top-row / left-column neighbour fetches to the intra predictor.
module intra_frame_store #(
    parameter int FRAME_W  = 1280,
    parameter int FRAME_H  = 720,
    parameter int MB_W     = 8,
    parameter int MB_H     = 8,
    parameter int PIX_BITS = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [31:0]                   in_mbnumber,
    input  logic [MB_W*MB_H*PIX_BITS-1:0] in_pixels,
    output logic                          wr_done,
    output logic                          wr_err,
    input  logic                          nb_req,
    output logic                          nb_ready,
    input  logic [31:0]                   nb_mbnumber,
    output logic                          nb_valid,
    output logic [MB_W*PIX_BITS-1:0]      nb_top,
    output logic [MB_H*PIX_BITS-1:0]      nb_left,
    output logic                          nb_top_avail,
    output logic                          nb_left_avail
);
    import intra_pkg::*;

    localparam int ROW_BITS = MB_W * PIX_BITS;
    localparam int COL_BITS = MB_H * PIX_BITS;
    localparam int MB_BITS  = ROW_BITS * MB_H;
    localparam int DEPTH    = FRAME_H * (FRAME_W / MB_W);
    localparam int CNT_W    = (MB_H > 1) ? $clog2(MB_H) : 1;

    localparam logic [31:0]          WPR      = 32'(FRAME_W / MB_W);
    localparam logic [31:0]          FW32     = 32'(FRAME_W);
    localparam logic [31:0]          FH32     = 32'(FRAME_H);
    localparam logic [31:0]          MBW32    = 32'(MB_W);
    localparam logic [31:0]          MBH32    = 32'(MB_H);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(MB_H - 1);
    localparam logic [PIX_BITS-1:0]  MID      = PIX_BITS'(mid_pixel(PIX_BITS));
    localparam logic [ROW_BITS-1:0]  TOP_FILL = {MB_W{MID}};
    localparam logic [COL_BITS-1:0]  LEFT_FILL = {MB_H{MID}};

    state_t                r_state, w_next_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [31:0]           r_row, r_col;
    logic [MB_BITS-1:0]    r_mb_pix;
    logic [ROW_BITS-1:0]   r_top_buf;
    logic [COL_BITS-1:0]   r_left_buf;

    logic [31:0]           w_in_row, w_in_col, w_nb_row, w_nb_col;
    logic                  w_in_ok, w_wr_accept, w_nb_accept, w_cnt_last;
    logic                  w_top_avail, w_left_avail;
    logic                  w_wr_done_nx, w_wr_err_nx, w_nb_valid_nx;
    logic                  w_ram_we;
    logic [31:0]           w_ram_addr;
    logic [ROW_BITS-1:0]   w_rd_data;
    logic [PIX_BITS-1:0]   w_left_pix;
    logic [COL_BITS-1:0]   w_left_shift;

    assign w_in_row = mb_row(in_mbnumber);
    assign w_in_col = mb_col(in_mbnumber);
    assign w_nb_row = mb_row(nb_mbnumber);
    assign w_nb_col = mb_col(nb_mbnumber);

    assign w_in_ok = (w_in_row % MBH32 == 0) && (w_in_col % MBW32 == 0) &&
                     (w_in_col + MBW32 <= FW32) && (w_in_row + MBH32 <= FH32);

    // Writes have priority: a pending macroblock hides the fetch port.
    assign in_ready    = (r_state == IDLE);
    assign nb_ready    = (r_state == IDLE) && !in_valid;
    assign w_wr_accept = in_valid && in_ready;
    assign w_nb_accept = nb_req && nb_ready;

    assign w_cnt_last   = (r_cnt == CNT_LAST);
    assign w_top_avail  = (r_row != 0);
    assign w_left_avail = (r_col != 0);

    // Left column is assembled by shifting each word's rightmost pixel in from the top.
    assign w_left_pix   = w_rd_data[(MB_W-1)*PIX_BITS +: PIX_BITS];
    assign w_left_shift = {w_left_pix, {(COL_BITS-PIX_BITS){1'b0}}} | (r_left_buf >> PIX_BITS);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // NOTE: every output of this block gets a default first so no latch can be inferred.
    always_comb begin
        w_next_state  = r_state;
        w_wr_done_nx  = 1'b0;
        w_wr_err_nx   = 1'b0;
        w_nb_valid_nx = 1'b0;
        w_ram_we      = 1'b0;
        w_ram_addr    = '0;
        unique case (r_state)
            IDLE: begin
                if (w_wr_accept) begin
                    if (w_in_ok) w_next_state = WRITE;
                    else         w_wr_err_nx  = 1'b1;
                end else if (w_nb_accept) begin
                    w_next_state = RD_TOP;
                end
            end
            WRITE: begin
                w_ram_we   = 1'b1;
                w_ram_addr = (r_row + 32'(r_cnt)) * WPR + r_col / MBW32;
                if (w_cnt_last) begin
                    w_next_state = IDLE;
                    w_wr_done_nx = 1'b1;
                end
            end
            RD_TOP: begin
                w_ram_addr   = w_top_avail ? (r_row - 32'd1) * WPR + r_col / MBW32 : '0;
                w_next_state = RD_LEFT;
            end
            RD_LEFT: begin
                w_ram_addr = w_left_avail ?
                             (r_row + 32'(r_cnt)) * WPR + r_col / MBW32 - 32'd1 : '0;
                if (w_cnt_last) w_next_state = RD_DONE;
            end
            RD_DONE: begin
                w_next_state  = IDLE;
                w_nb_valid_nx = 1'b1;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt         <= '0;
            wr_done       <= 1'b0;
            wr_err        <= 1'b0;
            nb_valid      <= 1'b0;
            nb_top        <= '0;
            nb_left       <= '0;
            nb_top_avail  <= 1'b0;
            nb_left_avail <= 1'b0;
        end else begin
            wr_done  <= w_wr_done_nx;
            wr_err   <= w_wr_err_nx;
            nb_valid <= w_nb_valid_nx;
            if (r_state == WRITE || r_state == RD_LEFT)
                r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
            if (r_state == RD_DONE) begin
                nb_top        <= w_top_avail  ? r_top_buf    : TOP_FILL;
                nb_left       <= w_left_avail ? w_left_shift : LEFT_FILL;
                nb_top_avail  <= w_top_avail;
                nb_left_avail <= w_left_avail;
            end
        end
    end

    // Read data lags the address by one cycle: top word arrives in the first RD_LEFT cycle.
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_row    <= w_in_row;
            r_col    <= w_in_col;
            r_mb_pix <= in_pixels;
        end else if (w_nb_accept) begin
            r_row <= w_nb_row;
            r_col <= w_nb_col;
        end
        if (r_state == WRITE)
            r_mb_pix <= r_mb_pix >> ROW_BITS;
        if (r_state == RD_LEFT) begin
            if (r_cnt == '0) r_top_buf  <= w_rd_data;
            else             r_left_buf <= w_left_shift;
        end
    end

    frame_store_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ROW_BITS)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (r_mb_pix[ROW_BITS-1:0]),
        .o_rdata (w_rd_data)
    );

endmodule
